// File: rtl/fc1004_audio_pkg.sv
// Shared widths, sample types and the output saturation helper for the fc1004 audio mixer.
package fc1004_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned FM_W     = 9;
    localparam int unsigned ACC_W    = 14;
    localparam int unsigned MIX_W    = 20;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_t;

    // Clamp a MIX_W-bit two's complement value into the signed SAMPLE_W range.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [MIX_W-1:0] x);
        if (x[MIX_W-1:SAMPLE_W-1] == {(MIX_W-SAMPLE_W+1){x[MIX_W-1]}})
            return x[SAMPLE_W-1:0];
        return x[MIX_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fc1004_audio_mix_if.sv
// Stereo sample stream with valid/ready handshake between the mixer and its consumer.
interface fc1004_audio_mix_if;
    import fc1004_audio_pkg::*;

    logic [SAMPLE_W-1:0] out_l;
    logic [SAMPLE_W-1:0] out_r;
    logic                out_valid;
    logic                out_ready;

    modport master (output out_l, output out_r, output out_valid, input out_ready);
    modport slave  (input out_l, input out_r, input out_valid, output out_ready);

endinterface

// File: rtl/fc1004_audio_fifo.sv
// Synchronous stereo-sample FIFO; drops writes when full (unless popping) and flags it stickily.
module fc1004_audio_fifo
    import fc1004_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  stereo_t wr_data,
    input  logic    rd_en,
    output stereo_t rd_data,
    output logic    empty,
    output logic    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    stereo_t       mem [DEPTH];
    stereo_t       last_q;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          pop;
    logic          push;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = rd_en & ~empty;
        push    = wr_en & (~full | pop);
        // When empty the head output keeps showing the last sample popped.
        rd_data = empty ? last_q : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                last_q <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (wr_en && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/fc1004_audio_mix.sv
// FM frame integrator (stage 1), PSG mix and saturation (stage 2) feeding the output sample FIFO.
module fc1004_audio_mix
    import fc1004_audio_pkg::*;
#(
    parameter int unsigned FM_SLOTS   = 24,
    parameter int unsigned FM_SHIFT   = 2,
    parameter int unsigned PSG_SHIFT  = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                MCLK,
    input  logic                RESET,
    input  logic                fm_tick,
    input  logic                fm_sync,
    input  logic [FM_W-1:0]     MOL,
    input  logic [FM_W-1:0]     MOR,
    input  logic [SAMPLE_W-1:0] PSG,
    input  logic                mix_en,
    fc1004_audio_mix_if.master  aout,
    output logic                overflow,
    output logic                resync
);

    localparam int unsigned SLOT_W = $clog2(FM_SLOTS);

    logic [SLOT_W-1:0]   slot;
    logic [ACC_W-1:0]    acc_l, acc_r;
    logic [ACC_W-1:0]    smp_l, smp_r;
    logic [ACC_W-1:0]    sum_l, sum_r;
    logic                tick_en, do_resync, do_close;

    logic [ACC_W-1:0]    frame_l, frame_r;
    logic [SAMPLE_W-1:0] frame_psg;
    logic                frame_valid;

    logic [SAMPLE_W-1:0]    psg_s;
    logic signed [MIX_W-1:0] psg_w, fm_l_w, fm_r_w, mix_l, mix_r;
    stereo_t             wr_data;
    stereo_t             head;
    logic                fifo_empty;

    always_comb begin
        smp_l     = {{(ACC_W-FM_W){MOL[FM_W-1]}}, MOL};
        smp_r     = {{(ACC_W-FM_W){MOR[FM_W-1]}}, MOR};
        sum_l     = acc_l + smp_l;
        sum_r     = acc_r + smp_r;
        tick_en   = fm_tick & mix_en;
        // A resync takes priority over closing, so a sync on the last slot still discards the frame.
        do_resync = tick_en & fm_sync & (slot != '0);
        do_close  = tick_en & ~do_resync & (slot == SLOT_W'(FM_SLOTS - 1));
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            slot        <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            frame_l     <= '0;
            frame_r     <= '0;
            frame_psg   <= '0;
            frame_valid <= 1'b0;
            resync      <= 1'b0;
        end else begin
            frame_valid <= do_close;
            resync      <= do_resync;
            if (!mix_en) begin
                slot  <= '0;
                acc_l <= '0;
                acc_r <= '0;
            end else if (do_resync) begin
                slot  <= SLOT_W'(1);
                acc_l <= smp_l;
                acc_r <= smp_r;
            end else if (do_close) begin
                slot      <= '0;
                acc_l     <= '0;
                acc_r     <= '0;
                frame_l   <= sum_l;
                frame_r   <= sum_r;
                frame_psg <= PSG;
            end else if (fm_tick) begin
                slot  <= slot + SLOT_W'(1);
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
        end
    end

    // Offset-binary PSG becomes two's complement by flipping the MSB.
    always_comb begin
        psg_s     = {~frame_psg[SAMPLE_W-1], frame_psg[SAMPLE_W-2:0]};
        psg_w     = $signed({{(MIX_W-SAMPLE_W){psg_s[SAMPLE_W-1]}}, psg_s}) >>> PSG_SHIFT;
        fm_l_w    = $signed({{(MIX_W-ACC_W){frame_l[ACC_W-1]}}, frame_l}) <<< FM_SHIFT;
        fm_r_w    = $signed({{(MIX_W-ACC_W){frame_r[ACC_W-1]}}, frame_r}) <<< FM_SHIFT;
        mix_l     = fm_l_w + psg_w;
        mix_r     = fm_r_w + psg_w;
        wr_data.l = saturate(mix_l);
        wr_data.r = saturate(mix_r);
    end

    fc1004_audio_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (MCLK),
        .rst      (RESET),
        .wr_en    (frame_valid),
        .wr_data  (wr_data),
        .rd_en    (aout.out_ready),
        .rd_data  (head),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    always_comb begin
        aout.out_l     = head.l;
        aout.out_r     = head.r;
        aout.out_valid = ~fifo_empty;
    end

endmodule

// File: tb/tb_fc1004_audio_mix.sv
// Directed bench for fc1004_audio_mix with a frame-level scoreboard; a second instance uses FM_SHIFT=3.
module tb_fc1004_audio_mix;
    import fc1004_audio_pkg::*;

    logic        MCLK = 1'b0;
    logic        RESET, fm_tick, fm_sync, mix_en, ready;
    logic [8:0]  MOL, MOR;
    logic [15:0] PSG;
    logic        overflow, resync, overflow3, resync3;

    int unsigned checks = 0;
    int unsigned errors = 0;

    stereo_t q[$];
    stereo_t q3[$];
    logic [15:0] last_l;
    int m_slot, m_acc_l, m_acc_r;

    fc1004_audio_mix_if bus ();
    fc1004_audio_mix_if bus3 ();
    assign bus.out_ready  = ready;
    assign bus3.out_ready = ready;

    always #5 MCLK = ~MCLK;

    fc1004_audio_mix dut (
        .MCLK(MCLK), .RESET(RESET), .fm_tick(fm_tick), .fm_sync(fm_sync),
        .MOL(MOL), .MOR(MOR), .PSG(PSG), .mix_en(mix_en),
        .aout(bus), .overflow(overflow), .resync(resync)
    );

    fc1004_audio_mix #(.FM_SHIFT(3)) dut3 (
        .MCLK(MCLK), .RESET(RESET), .fm_tick(fm_tick), .fm_sync(fm_sync),
        .MOL(MOL), .MOR(MOR), .PSG(PSG), .mix_en(mix_en),
        .aout(bus3), .overflow(overflow3), .resync(resync3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_mix(input int fr, input logic [15:0] psg, input int shift);
        int p, m;
        p = int'(psg) - 32768;
        p = p >>> 3;
        m = fr * (1 << shift) + p;
        if (m > 32767)  m = 32767;
        if (m < -32768) m = -32768;
        return m[15:0];
    endfunction

    // Reference FIFO occupancy: with frames 24+ cycles apart the queue size equals DUT occupancy.
    task automatic push_frame(input int fl, input int fr, input logic [15:0] psg);
        if (q.size() < 4) begin
            q.push_back('{l: exp_mix(fl, psg, 2), r: exp_mix(fr, psg, 2)});
            q3.push_back('{l: exp_mix(fl, psg, 3), r: exp_mix(fr, psg, 3)});
        end
    endtask

    task automatic tick(input int l, input int r, input bit sync, input logic [15:0] psg);
        fm_tick = 1'b1; fm_sync = sync; MOL = 9'(l); MOR = 9'(r); PSG = psg;
        @(posedge MCLK); #1;
        if (mix_en) begin
            if (sync && m_slot != 0) begin
                m_acc_l = l; m_acc_r = r; m_slot = 1;
            end else if (m_slot == 23) begin
                push_frame(m_acc_l + l, m_acc_r + r, psg);
                m_acc_l = 0; m_acc_r = 0; m_slot = 0;
            end else begin
                m_acc_l += l; m_acc_r += r; m_slot++;
            end
        end
    endtask

    task automatic send_frame(input int l, input int r, input logic [15:0] psg);
        for (int i = 0; i < 24; i++) tick(l, r, i == 0, psg);
    endtask

    task automatic idle(input int n);
        fm_tick = 1'b0; fm_sync = 1'b0;
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && q3.size() == 0) break;
            idle(1);
        end
    endtask

    always @(negedge MCLK) begin
        if (!RESET && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_sample: observed=0x%0h expected=none", bus.out_l);
            end else begin
                stereo_t e;
                e = q.pop_front();
                chk("out_l", bus.out_l, e.l);
                chk("out_r", bus.out_r, e.r);
                last_l = e.l;
            end
        end
        if (!RESET && bus3.out_valid && bus3.out_ready) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_sample3: observed=0x%0h expected=none", bus3.out_l);
            end else begin
                stereo_t e3;
                e3 = q3.pop_front();
                chk("out_l_sh3", bus3.out_l, e3.l);
                chk("out_r_sh3", bus3.out_r, e3.r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=no finish expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        RESET = 1'b1; fm_tick = 1'b0; fm_sync = 1'b0; mix_en = 1'b1; ready = 1'b1;
        MOL = '0; MOR = '0; PSG = 16'h8000; last_l = '0;
        m_slot = 0; m_acc_l = 0; m_acc_r = 0;
        @(posedge MCLK); @(posedge MCLK); #1;
        RESET = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_out_l", bus.out_l, 0);
        chk("rst_out_r", bus.out_r, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_resync", resync, 0);
        chk("rst_valid_sh3", bus3.out_valid, 0);

        // Basic frame and latency: not valid in t+1, valid in t+2.
        send_frame(10, -10, 16'h8000);
        chk("lat_t1_valid", bus.out_valid, 0);
        idle(1);
        chk("lat_t2_valid", bus.out_valid, 1);
        idle(3);

        // PSG only, both extremes.
        send_frame(0, 0, 16'hFFFF); idle(3);
        send_frame(0, 0, 16'h0000); idle(3);

        // Saturation on the FM_SHIFT=3 instance, both rails.
        send_frame(255, -256, 16'hFFFF); idle(3);
        send_frame(-256, 255, 16'h0000); idle(3);

        // Sync at slot 10 discards the partial frame.
        for (int i = 0; i < 10; i++) tick(3, -3, i == 0, 16'h8000);
        tick(7, -7, 1'b1, 16'h8000);
        chk("resync_pulse", resync, 1);
        tick(7, -7, 1'b0, 16'h8000);
        chk("resync_one_cycle", resync, 0);
        for (int i = 0; i < 22; i++) tick(7, -7, 1'b0, 16'h8000);
        idle(3);
        send_frame(5, -6, 16'h9000); idle(3);
        wait_drain();

        // Overflow: five frames into a four-deep queue with the consumer stalled.
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [15:0] psg_k;
            psg_k = 16'(32768 + k * 256);
            send_frame(k + 1, -2 * (k + 1), psg_k);
        end
        idle(3);
        chk("overflow_flag", overflow, 1);
        chk("overflow_flag_sh3", overflow3, 1);
        chk("stalled_valid", bus.out_valid, 1);
        chk("stalled_head_l", bus.out_l, q[0].l);
        idle(2);
        chk("stalled_head_hold", bus.out_l, q[0].l);
        ready = 1'b1;
        wait_drain();
        chk("drained_valid", bus.out_valid, 0);
        chk("empty_holds_last", bus.out_l, last_l);

        // mix_en falling right after a close still delivers that frame.
        send_frame(20, -20, 16'h8000);
        mix_en = 1'b0;
        idle(3);
        for (int i = 0; i < 30; i++) tick(50, 50, 1'b0, 16'h8000);
        idle(3);
        wait_drain();
        chk("mix_off_valid", bus.out_valid, 0);
        mix_en = 1'b1;
        send_frame(9, -9, 16'h8000); idle(3);
        wait_drain();

        // Reset between the closing tick and the FIFO write.
        send_frame(11, -11, 16'h8000);
        RESET = 1'b1;
        @(posedge MCLK); #1;
        RESET = 1'b0;
        void'(q.pop_back());
        void'(q3.pop_back());
        m_slot = 0; m_acc_l = 0; m_acc_r = 0;
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_out_l", bus.out_l, 0);
        chk("rst2_out_r", bus.out_r, 0);
        chk("rst2_overflow", overflow, 0);
        idle(4);
        chk("rst2_no_sample", bus.out_valid, 0);
        send_frame(4, -4, 16'hA000); idle(3);

        wait_drain();
        chk("drain_all", q.size() + q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
